thread_regfile: RTL
===================

THREAD_REGFILE -- requirements
Module: thread_regfile

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4, is the number of thread lanes; it is also the value returned as blockDim.
REQ-002 clk  in  1  clock; reset is sampled on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; clock clk.
REQ-004 enable  in  1  block active; when low, all state and outputs hold.
REQ-005 thread_enable  in  THREADS_PER_BLOCK  per-lane write mask; bit i high means lane i is live.
REQ-006 core_state  in  3  core FSM state: 011 = REQUEST, 110 = UPDATE; all other codes are no-op.
REQ-007 block_id  in  8  index of the dispatched block.
REQ-008 decoded_rd_address, decoded_rs_address, decoded_rt_address  in  4 each  register indices.
REQ-009 decoded_reg_write_enable  in  1  instruction writes rd.
REQ-010 decoded_reg_input_mux  in  2  write source: 00 = ALU, 01 = LSU, 10 = immediate, 11 = no write.
REQ-011 decoded_immediate  in  8  constant for CONST instructions.
REQ-012 alu_out, lsu_out  in  8 x THREADS_PER_BLOCK  per-lane results.
REQ-013 rs, rt  out  8 x THREADS_PER_BLOCK  registered per-lane operands for the ALU and LSU.

Function
REQ-014 Each lane SHALL hold 16 x 8-bit registers: R0-R12 general-purpose, R13 = %blockIdx, R14 = %blockDim, R15 = %threadIdx.
REQ-015 R14 SHALL read as THREADS_PER_BLOCK and R15 SHALL read as the lane index i, both at all times.
REQ-016 R13 SHALL load block_id on every clock edge where enable is high and reset is low.
REQ-017 Read: on an edge with enable high and core_state == REQUEST, rs[i] and rt[i] SHALL load R[rs_address] and R[rt_address] of lane i; otherwise they hold, giving 1-cycle latency so operands are valid throughout WAIT and EXECUTE.
REQ-018 Reads SHALL occur in all lanes regardless of thread_enable.
REQ-019 Write: on an edge with enable high, core_state == UPDATE, decoded_reg_write_enable high, decoded_reg_input_mux != 11, rd_address < 13 and thread_enable[i] high, lane i's R[rd] SHALL load the selected source.
REQ-020 The selected source SHALL be alu_out[i], lsu_out[i] or decoded_immediate (broadcast to all lanes), according to decoded_reg_input_mux.
REQ-021 Writes with rd_address of 13-15 SHALL be silently dropped.
REQ-022 REQUEST and UPDATE are mutually exclusive, so no read/write bypass exists; a value written in UPDATE is visible at the next REQUEST.
REQ-023 Register values SHALL be stored unmodified (8-bit, no width change).
REQ-024 A lane with thread_enable low SHALL keep its register contents unchanged.

Reset
REQ-025 When reset is high on an edge, R0-R12 of every lane, R13, and all rs/rt outputs SHALL become 0; reset has priority over enable and core_state.
REQ-026 Reset asserted mid-instruction (e.g. during UPDATE) SHALL abort the pending write; all registers read 0 the following cycle.

Configuration
REQ-027 Macro REGFILE_ZERO_R0_EN: when defined, R0 SHALL always read 0 and writes to R0 SHALL be dropped; when undefined, R0 SHALL be an ordinary general-purpose register.

Structure
REQ-028 The shared package gpu_pkg SHALL hold the core_state encodings (REQUEST, UPDATE), the reg_input_mux encodings (ALU, LSU, CONST, NONE), and the special-register indices 13/14/15.
REQ-029 A sub-module regfile_lane, holding one lane's 16 registers and its read port, SHALL be generated THREADS_PER_BLOCK times; the top level handles broadcast and mux decode.

Verification
REQ-030 Reset, then issue a REQUEST with rs = 15, rt = 14 and block_id = 3 -> rs = {0,1,2,3}, rt = {4,4,4,4}; a separate REQUEST with rs = 13 -> rs = {3,3,3,3}.
REQ-031 UPDATE with mux = 10, imm = 0x5A, rd = 2, thread_enable = 1011, then REQUEST with rs = 2 -> rs = {5A,5A,00,5A} for lanes 0,1,2,3.
REQ-032 UPDATE with mux = 00, rd = 4, alu_out = {1,2,3,4}; then mux = 01, rd = 5, lsu_out = {9,8,7,6}; then REQUEST with rs = 4, rt = 5 -> rs = {1,2,3,4}, rt = {9,8,7,6}.
REQ-033 UPDATE to rd = 14 with imm = 0xFF, and separately an UPDATE with mux = 11 to rd = 3 -> R14 still reads 4 and R3 is unchanged.
REQ-034 Write 0x77 to R6, assert reset during the next UPDATE (imm = 0x11) -> R6 reads 0; with enable low during an UPDATE -> no change to registers or rs/rt.
REQ-035 With REGFILE_ZERO_R0_EN defined, write 0x33 to R0 -> R0 reads 0; with it undefined -> R0 reads 0x33.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared encodings for the per-thread register file
//
// Purpose: core FSM state codes used by the register file, write-source
// mux encodings, and the indices of the read-only special registers.
// Ports: none (package).
package gpu_pkg;

  // Core FSM states the register file reacts to; every other code is a no-op.
  localparam logic [2:0] STATE_REQUEST = 3'b011;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;

  // Register write source selection.
  typedef enum logic [1:0] {
    MUX_ALU   = 2'b00,
    MUX_LSU   = 2'b01,
    MUX_CONST = 2'b10,
    MUX_NONE  = 2'b11
  } reg_input_mux_e;

  // Special register indices (read-only from the instruction stream).
  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;

  localparam int NUM_GP_REGS = 13;

endpackage

// File: rtl/regfile_lane.sv
// rtl/regfile_lane.sv - one thread lane: 16 x 8-bit registers and registered read port
//
// Purpose: holds R0-R12 general-purpose registers and the %blockIdx copy
// for a single lane; R14/R15 are constants. Loads rs/rt on read_en.
// Optional macro: REGFILE_ZERO_R0_EN (R0 hardwired to zero).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          block active; all state holds when low
//   block_id        loaded into R13 every enabled cycle
//   read_en         load rs/rt from rs_address/rt_address this edge
//   rs_address, rt_address  read indices
//   write_en        write write_data into R[rd_address] this edge
//   rd_address, write_data  write index and value
//   rs, rt          registered operands
module regfile_lane
  import gpu_pkg::*;
#(
  parameter int LANE_ID           = 0,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] block_id,
  input  logic       read_en,
  input  logic [3:0] rs_address,
  input  logic [3:0] rt_address,
  input  logic       write_en,
  input  logic [3:0] rd_address,
  input  logic [7:0] write_data,
  output logic [7:0] rs,
  output logic [7:0] rt
);

  logic [7:0] gp_regs [0:NUM_GP_REGS-1];
  logic [7:0] block_idx;

  // Architectural view of all 16 registers, special ones included.
  logic [7:0] reg_view [0:15];

  always_comb begin
    for (int r = 0; r < NUM_GP_REGS; r++) begin
      reg_view[r] = gp_regs[r];
    end
    reg_view[REG_BLOCK_IDX]  = block_idx;
    reg_view[REG_BLOCK_DIM]  = 8'(THREADS_PER_BLOCK);
    reg_view[REG_THREAD_IDX] = 8'(LANE_ID);
`ifdef REGFILE_ZERO_R0_EN
    reg_view[0] = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_GP_REGS; r++) begin
        gp_regs[r] <= 8'h00;
      end
      block_idx <= 8'h00;
      rs        <= 8'h00;
      rt        <= 8'h00;
    end else if (enable) begin
      block_idx <= block_id;
      if (read_en) begin
        rs <= reg_view[rs_address];
        rt <= reg_view[rt_address];
      end
      // Loop compare keeps the write decode inside R0-R12; indices 13-15
      // never match and are dropped.
      for (int r = 0; r < NUM_GP_REGS; r++) begin
`ifdef REGFILE_ZERO_R0_EN
        if (write_en && r != 0 && rd_address == 4'(r)) begin
          gp_regs[r] <= write_data;
        end
`else
        if (write_en && rd_address == 4'(r)) begin
          gp_regs[r] <= write_data;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/thread_regfile.sv
// rtl/thread_regfile.sv - per-thread register file for a SIMT compute block
//
// Purpose: instantiates one regfile_lane per thread lane, decodes the core
// state into read/write strobes and selects the per-lane write source.
// Optional macro: REGFILE_ZERO_R0_EN (R0 reads 0, writes to R0 dropped).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     block active; everything holds when low
//   thread_enable              per-lane write mask
//   core_state                 011 = REQUEST (read), 110 = UPDATE (write)
//   block_id                   dispatched block index, mirrored in R13
//   decoded_rd/rs/rt_address   register indices
//   decoded_reg_write_enable   instruction writes rd
//   decoded_reg_input_mux      00 ALU, 01 LSU, 10 immediate, 11 none
//   decoded_immediate          broadcast constant
//   alu_out, lsu_out           per-lane results
//   rs, rt                     registered per-lane operands
module thread_regfile
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [THREADS_PER_BLOCK-1:0]      thread_enable,
  input  logic [2:0]                        core_state,
  input  logic [7:0]                        block_id,
  input  logic [3:0]                        decoded_rd_address,
  input  logic [3:0]                        decoded_rs_address,
  input  logic [3:0]                        decoded_rt_address,
  input  logic                              decoded_reg_write_enable,
  input  logic [1:0]                        decoded_reg_input_mux,
  input  logic [7:0]                        decoded_immediate,
  input  logic [THREADS_PER_BLOCK-1:0][7:0] alu_out,
  input  logic [THREADS_PER_BLOCK-1:0][7:0] lsu_out,
  output logic [THREADS_PER_BLOCK-1:0][7:0] rs,
  output logic [THREADS_PER_BLOCK-1:0][7:0] rt
);

  logic read_en;
  logic write_common;

  assign read_en = (core_state == STATE_REQUEST);

  // Lane-independent write qualification; the lane mask is applied below.
  assign write_common = (core_state == STATE_UPDATE)
                     && decoded_reg_write_enable
                     && (decoded_reg_input_mux != MUX_NONE)
                     && (decoded_rd_address < REG_BLOCK_IDX);

  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_lane
    logic [7:0] write_data;

    always_comb begin
      write_data = decoded_immediate;
      case (decoded_reg_input_mux)
        MUX_ALU: write_data = alu_out[i];
        MUX_LSU: write_data = lsu_out[i];
        default: write_data = decoded_immediate;
      endcase
    end

    regfile_lane #(
      .LANE_ID           (i),
      .THREADS_PER_BLOCK (THREADS_PER_BLOCK)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .block_id   (block_id),
      .read_en    (read_en),
      .rs_address (decoded_rs_address),
      .rt_address (decoded_rt_address),
      .write_en   (write_common && thread_enable[i]),
      .rd_address (decoded_rd_address),
      .write_data (write_data),
      .rs         (rs[i]),
      .rt         (rt[i])
    );
  end

endmodule
